ddr_score_judge: RTL

- Judges each player's debounced arrow presses against the note stream and keeps score, combo and a per-hit judgement for both players.
- Sits directly downstream of input_processing (consumes a_out/b_out) and beside the controller, gated by game_active.
- Produces player_a_won / player_b_won / tie and game_over for the win-screen mux and the controller.
- Two identical judge lanes (A, B) share one note stream; a small top FSM owns game start/end.

---
 rtl/ddr_pkg.sv | 42 ++++
 rtl/ddr_judge_lane.sv | 151 +++++++++++++++
 rtl/ddr_score_judge.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ddr_pkg.sv
// ddr_pkg: shared judge codes, point values, state encodings and arrow
// indices for the DDR score judge (ddr_score_judge / ddr_judge_lane).
package ddr_pkg;

    typedef enum logic [1:0] {
        JUDGE_NONE    = 2'd0,
        JUDGE_PERFECT = 2'd1,
        JUDGE_GOOD    = 2'd2,
        JUDGE_MISS    = 2'd3
    } judge_e;

    typedef enum logic [1:0] {
        GAME_IDLE = 2'd0,
        GAME_PLAY = 2'd1,
        GAME_DONE = 2'd2
    } game_state_e;

    typedef enum logic {
        LANE_CLOSED = 1'b0,
        LANE_OPEN   = 1'b1
    } lane_state_e;

    localparam logic [2:0] PTS_PERFECT = 3'd2;
    localparam logic [2:0] PTS_GOOD    = 3'd1;

    // Combo (before the hit) at or above which a hit scores double
    localparam int COMBO_BONUS_THRESH = 10;

    // Arrow bit positions inside note_mask / button vectors
    localparam int UP    = 0;
    localparam int DOWN  = 1;
    localparam int LEFT  = 2;
    localparam int RIGHT = 3;

    // Points for one hit; the bonus doubles the base value
    function automatic logic [2:0] hit_points(input logic perfect, input logic bonus);
        logic [2:0] base;
        base = perfect ? PTS_PERFECT : PTS_GOOD;
        return bonus ? {base[1:0], 1'b0} : base;
    endfunction

endpackage

// File: rtl/ddr_judge_lane.sv
// ddr_judge_lane: one player's judge. Detects rising button edges, runs the
// hit window for the current note and keeps score, combo and last judgement.
// Optional: COMBO_BONUS_EN doubles hit points while combo >= 10.
module ddr_judge_lane
    import ddr_pkg::*;
#(
    parameter int WINDOW_CYCLES  = 12_500_000,
    parameter int PERFECT_CYCLES = 3_750_000,
    parameter int SCORE_W        = 16,
    parameter int COMBO_W        = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_clr,
    input  logic               i_pause,
    input  logic               i_note_valid,
    input  logic [3:0]         i_note_mask,
    input  logic               i_end,
    input  logic [3:0]         i_btn,
    output logic [SCORE_W-1:0] o_score,
    output logic [SCORE_W-1:0] o_score_nxt,
    output logic [COMBO_W-1:0] o_combo,
    output logic [1:0]         o_judge,
    output logic               o_strobe
);

    localparam int CNT_W = $clog2(WINDOW_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] PERF_CNT = CNT_W'(PERFECT_CYCLES);

    lane_state_e        r_state;
    logic [3:0]         r_btn_q;
    logic [3:0]         r_mask;
    logic [CNT_W-1:0]   r_elapsed;
    logic [SCORE_W-1:0] r_score;
    logic [COMBO_W-1:0] r_combo;
    judge_e             r_judge;
    logic               r_strobe;

    logic [3:0]         w_press;
    logic               w_live;
    logic               w_open;
    logic               w_note;
    logic               w_pressed;
    logic               w_hit;
    logic               w_timeout;
    logic               w_drop;
    logic               w_miss;
    logic               w_perfect;
    logic               w_bonus;
    logic [2:0]         w_pts;
    logic [SCORE_W-1:0] w_score_nxt;
    logic [COMBO_W-1:0] w_combo_nxt;

    function automatic logic [SCORE_W-1:0] sat_add_score(input logic [SCORE_W-1:0] a,
                                                         input logic [2:0] b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {{(SCORE_W-2){1'b0}}, b};
        return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

    function automatic logic [COMBO_W-1:0] sat_inc_combo(input logic [COMBO_W-1:0] c);
        return (&c) ? c : c + COMBO_W'(1);
    endfunction

    assign w_press   = i_btn & ~r_btn_q;
    assign w_live    = i_en & ~i_pause;
    assign w_open    = (r_state == LANE_OPEN);
    assign w_note    = w_live & i_note_valid & (i_note_mask != 4'd0);
    assign w_pressed = w_live & w_open & (w_press != 4'd0);
    assign w_hit     = w_pressed & (w_press == r_mask);
    assign w_timeout = w_live & w_open & (r_elapsed == LAST_CNT);
    // A press always wins over expiry, a replacing note or song end
    assign w_drop    = i_en & w_open & ~w_pressed & (w_timeout | w_note | i_end);
    assign w_miss    = (w_pressed & ~w_hit) | w_drop;
    assign w_perfect = (r_elapsed < PERF_CNT);

`ifdef COMBO_BONUS_EN
    assign w_bonus = (r_combo >= COMBO_W'(COMBO_BONUS_THRESH));
`else
    assign w_bonus = 1'b0;
`endif

    assign w_pts = hit_points(w_perfect, w_bonus);

    // Next score/combo, also exported so the result compare sees same-cycle hits
    always_comb begin
        w_score_nxt = r_score;
        w_combo_nxt = r_combo;
        if (i_clr) begin
            w_score_nxt = '0;
            w_combo_nxt = '0;
        end else if (w_hit) begin
            w_score_nxt = sat_add_score(r_score, w_pts);
            w_combo_nxt = sat_inc_combo(r_combo);
        end else if (w_miss) begin
            w_combo_nxt = '0;
        end
    end

    // Lane FSM: window open/close, elapsed counter, judgement and strobe
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= LANE_CLOSED;
            r_btn_q   <= '0;
            r_mask    <= '0;
            r_elapsed <= '0;
            r_score   <= '0;
            r_combo   <= '0;
            r_judge   <= JUDGE_NONE;
            r_strobe  <= 1'b0;
        end else begin
            r_btn_q  <= i_btn;
            r_score  <= w_score_nxt;
            r_combo  <= w_combo_nxt;
            r_strobe <= 1'b0;
            if (i_clr) begin
                r_state   <= LANE_CLOSED;
                r_elapsed <= '0;
                r_judge   <= JUDGE_NONE;
            end else if (!i_en) begin
                r_state <= LANE_CLOSED;
            end else begin
                if (w_hit) begin
                    r_judge  <= w_perfect ? JUDGE_PERFECT : JUDGE_GOOD;
                    r_strobe <= 1'b1;
                end else if (w_miss) begin
                    r_judge  <= JUDGE_MISS;
                    r_strobe <= 1'b1;
                end
                if (w_note) begin
                    r_state   <= LANE_OPEN;
                    r_mask    <= i_note_mask;
                    r_elapsed <= '0;
                end else if (w_hit | w_miss) begin
                    r_state <= LANE_CLOSED;
                end else if (w_live & w_open) begin
                    r_elapsed <= r_elapsed + CNT_W'(1);
                end
            end
        end
    end

    assign o_score     = r_score;
    assign o_score_nxt = w_score_nxt;
    assign o_combo     = r_combo;
    assign o_judge     = r_judge;
    assign o_strobe    = r_strobe;

endmodule

// File: rtl/ddr_score_judge.sv
// ddr_score_judge: two-player DDR judge. Game FSM (IDLE/PLAY/DONE) plus two
// ddr_judge_lane instances sharing one note stream, and the final result.
// Optional: define COMBO_BONUS_EN to double hit points while combo >= 10.
module ddr_score_judge
    import ddr_pkg::*;
#(
    parameter int WINDOW_CYCLES  = 12_500_000,
    parameter int PERFECT_CYCLES = 3_750_000,
    parameter int SCORE_W        = 16,
    parameter int COMBO_W        = 8
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic               game_active,
    input  logic               pause,
    input  logic               note_valid,
    input  logic [3:0]         note_mask,
    input  logic               song_done,
    input  logic [3:0]         a_btn,
    input  logic [3:0]         b_btn,
    output logic [SCORE_W-1:0] a_score,
    output logic [SCORE_W-1:0] b_score,
    output logic [COMBO_W-1:0] a_combo,
    output logic [COMBO_W-1:0] b_combo,
    output logic [1:0]         a_judge,
    output logic [1:0]         b_judge,
    output logic               a_strobe,
    output logic               b_strobe,
    output logic               game_over,
    output logic               player_a_won,
    output logic               player_b_won,
    output logic               tie
);

    game_state_e r_state;
    logic        r_ga_q;
    logic        r_game_over;
    logic        r_a_won;
    logic        r_b_won;
    logic        r_tie;

    logic               w_ga_rise;
    logic               w_ga_fall;
    logic               w_play;
    logic               w_clr;
    logic               w_end;
    logic               w_finish;
    logic [SCORE_W-1:0] w_a_score_nxt;
    logic [SCORE_W-1:0] w_b_score_nxt;

    assign w_ga_rise = game_active & ~r_ga_q;
    assign w_ga_fall = ~game_active & r_ga_q;
    assign w_play    = (r_state == GAME_PLAY);
    assign w_clr     = w_ga_rise & ~w_play;
    assign w_end     = w_play & song_done;
    // A controller drop of game_active during pause is not treated as game end
    assign w_finish  = w_play & (song_done | (w_ga_fall & ~pause));

    ddr_judge_lane #(
        .WINDOW_CYCLES (WINDOW_CYCLES),
        .PERFECT_CYCLES(PERFECT_CYCLES),
        .SCORE_W       (SCORE_W),
        .COMBO_W       (COMBO_W)
    ) u_lane_a (
        .i_clk       (CLOCK_50),
        .i_rst_n     (resetn),
        .i_en        (w_play),
        .i_clr       (w_clr),
        .i_pause     (pause),
        .i_note_valid(note_valid),
        .i_note_mask (note_mask),
        .i_end       (w_end),
        .i_btn       (a_btn),
        .o_score     (a_score),
        .o_score_nxt (w_a_score_nxt),
        .o_combo     (a_combo),
        .o_judge     (a_judge),
        .o_strobe    (a_strobe)
    );

    ddr_judge_lane #(
        .WINDOW_CYCLES (WINDOW_CYCLES),
        .PERFECT_CYCLES(PERFECT_CYCLES),
        .SCORE_W       (SCORE_W),
        .COMBO_W       (COMBO_W)
    ) u_lane_b (
        .i_clk       (CLOCK_50),
        .i_rst_n     (resetn),
        .i_en        (w_play),
        .i_clr       (w_clr),
        .i_pause     (pause),
        .i_note_valid(note_valid),
        .i_note_mask (note_mask),
        .i_end       (w_end),
        .i_btn       (b_btn),
        .o_score     (b_score),
        .o_score_nxt (w_b_score_nxt),
        .o_combo     (b_combo),
        .o_judge     (b_judge),
        .o_strobe    (b_strobe)
    );

    // Game FSM with registered game_over and result flags (latched on entry to DONE)
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_state     <= GAME_IDLE;
            r_ga_q      <= 1'b0;
            r_game_over <= 1'b0;
            r_a_won     <= 1'b0;
            r_b_won     <= 1'b0;
            r_tie       <= 1'b0;
        end else begin
            r_ga_q <= game_active;
            case (r_state)
                GAME_PLAY: begin
                    if (w_finish) begin
                        r_state     <= GAME_DONE;
                        r_game_over <= 1'b1;
                        // Next-score values include a hit judged in this same cycle
                        r_a_won     <= (w_a_score_nxt >  w_b_score_nxt);
                        r_b_won     <= (w_b_score_nxt >  w_a_score_nxt);
                        r_tie       <= (w_a_score_nxt == w_b_score_nxt);
                    end
                end
                default: begin
                    if (w_ga_rise) begin
                        r_state     <= GAME_PLAY;
                        r_game_over <= 1'b0;
                        r_a_won     <= 1'b0;
                        r_b_won     <= 1'b0;
                        r_tie       <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign game_over    = r_game_over;
    assign player_a_won = r_a_won;
    assign player_b_won = r_b_won;
    assign tie          = r_tie;

endmodule
